// File: rtl/fdiv_sched.sv
// Purpose: round-robin scheduler sharing one pipelined fdiv between two requesters (optional macro FDIV_SCHED_DZ_FLAG_EN).
// Latency: issue-to-response is exactly FDIV_LAT+1 cycles, in order, one operation per cycle.
// Backpressure: ready is a combinational grant to requests; responses have no backpressure.
module fdiv_sched #(
    parameter int FDIV_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    input  logic        req1_valid,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic [31:0] fdiv_x1,
    output logic [31:0] fdiv_x2,
    input  logic [31:0] fdiv_y,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp0_y,
    output logic [31:0] resp1_y,
    output logic [3:0]  inflight
`ifdef FDIV_SCHED_DZ_FLAG_EN
    ,
    output logic        resp0_dz,
    output logic        resp1_dz
`endif
);

    localparam int DEPTH = FDIV_LAT + 1;

    // Tag travelling alongside the operation through the fdiv pipeline.
    typedef struct packed {
        logic vld;
        logic id;
`ifdef FDIV_SCHED_DZ_FLAG_EN
        logic dz;
`endif
    } tag_t;

    tag_t tag_q [DEPTH];
    tag_t tag_in;
    tag_t tag_out;
    logic prio_q;   // 0: req0 has priority, 1: req1 has priority
    logic hs;

    // Grant: priority side wins a conflict, lone valid always wins, nothing during reset.
    always_comb begin
        req0_ready = !rst && req0_valid && (!req1_valid || !prio_q);
        req1_ready = !rst && req1_valid && (!req0_valid ||  prio_q);
        hs         = req0_ready || req1_ready;
        tag_in     = '0;
        tag_in.vld = hs;
        tag_in.id  = req1_ready;
`ifdef FDIV_SCHED_DZ_FLAG_EN
        tag_in.dz  = hs && ((req1_ready ? req1_x2[30:0] : req0_x2[30:0]) == 31'd0);
`endif
        tag_out    = tag_q[DEPTH-1];
    end

    // Round-robin pointer: the side just granted loses priority; idle cycles hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (req0_ready) begin
            prio_q <= 1'b1;
        end else if (req1_ready) begin
            prio_q <= 1'b0;
        end
    end

    // Operand register towards the fdiv; zero when nothing is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            fdiv_x1 <= '0;
            fdiv_x2 <= '0;
        end else if (req1_ready) begin
            fdiv_x1 <= req1_x1;
            fdiv_x2 <= req1_x2;
        end else if (req0_ready) begin
            fdiv_x1 <= req0_x1;
            fdiv_x2 <= req0_x2;
        end else begin
            fdiv_x1 <= '0;
            fdiv_x2 <= '0;
        end
    end

    // Tag shift register matching the fdiv latency; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Response steering: capture fdiv_y for the owner of the exiting tag, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_y     <= '0;
            resp1_y     <= '0;
`ifdef FDIV_SCHED_DZ_FLAG_EN
            resp0_dz    <= 1'b0;
            resp1_dz    <= 1'b0;
`endif
        end else begin
            resp0_valid <= tag_out.vld && !tag_out.id;
            resp1_valid <= tag_out.vld &&  tag_out.id;
            if (tag_out.vld && !tag_out.id) begin
                resp0_y  <= fdiv_y;
`ifdef FDIV_SCHED_DZ_FLAG_EN
                resp0_dz <= tag_out.dz;
`endif
            end
            if (tag_out.vld && tag_out.id) begin
                resp1_y  <= fdiv_y;
`ifdef FDIV_SCHED_DZ_FLAG_EN
                resp1_dz <= tag_out.dz;
`endif
            end
        end
    end

    // Outstanding-operation counter: issue adds one, delivery removes one.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({hs, tag_out.vld})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_sched.sv
// Bench for fdiv_sched with FDIV_LAT=2 and a small reference fdiv pipeline.
// Table of per-cycle grant vectors plus hand sequences for streaming, reset and dz.
// Responses are checked against a scoreboard filled at handshake time.
module tb_fdiv_sched;

    localparam int FDIV_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
    logic        req0_ready, req1_ready;
    logic [31:0] fdiv_x1, fdiv_x2, fdiv_y;
    logic        resp0_valid, resp1_valid;
    logic [31:0] resp0_y, resp1_y;
    logic [3:0]  inflight;
`ifdef FDIV_SCHED_DZ_FLAG_EN
    logic        resp0_dz, resp1_dz;
`endif

    fdiv_sched #(.FDIV_LAT(FDIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_x1(req0_x1), .req0_x2(req0_x2),
        .req1_valid(req1_valid), .req1_x1(req1_x1), .req1_x2(req1_x2),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .fdiv_x1(fdiv_x1), .fdiv_x2(fdiv_x2), .fdiv_y(fdiv_y),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_y(resp0_y), .resp1_y(resp1_y),
        .inflight(inflight)
`ifdef FDIV_SCHED_DZ_FLAG_EN
        , .resp0_dz(resp0_dz), .resp1_dz(resp1_dz)
`endif
    );

    always #5 clk = ~clk;

    // Reference quotients for the documented operand pairs; other pairs get a
    // deterministic scramble so misrouted results are still visible.
    function automatic logic [31:0] fref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40400000_40000000: fref = 32'h3FC00000;
            64'h437F0000_C37F0000: fref = 32'hBF800000;
            64'h40200000_40000000: fref = 32'h3FA00000;
            64'h3F800000_80000000: fref = 32'hFF800000;
            default:               fref = a ^ {b[15:0], b[31:16]} ^ 32'h13579BDF;
        endcase
    endfunction

    // Shared fdiv model: FDIV_LAT register stages.
    logic [31:0] p1, p2;
    always @(posedge clk) begin
        p1 <= fref(fdiv_x1, fdiv_x2);
        p2 <= p1;
    end
    assign fdiv_y = p2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] y;
        logic        dz;
        int          issue;
    } sb_t;
    sb_t sb[$];

    logic        mon_en = 1'b0;
    int          cnt = 0;
    int          peak = 0;
    int          r0_cnt = 0, r1_cnt = 0, r1_first = 0, r1_last = 0;
    logic [31:0] last0 = '0, last1 = '0;

    // Monitor: check responses, hold behaviour and inflight, then record new issues.
    always @(negedge clk) begin
        if (mon_en) begin
            sb_t e;
            chk("resp_excl", 32'(resp0_valid & resp1_valid), 32'd0);
            if (resp0_valid || resp1_valid) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", {30'd0, resp1_valid, resp0_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", 32'(resp1_valid), 32'(e.id));
                    chk("resp_y", e.id ? resp1_y : resp0_y, e.y);
                    chk("resp_lat", 32'(cyc - e.issue), 32'(FDIV_LAT + 1));
`ifdef FDIV_SCHED_DZ_FLAG_EN
                    chk("resp_dz", 32'(e.id ? resp1_dz : resp0_dz), 32'(e.dz));
`endif
                    cnt--;
                end
                if (resp0_valid) begin
                    r0_cnt++;
                    last0 = resp0_y;
                end
                if (resp1_valid) begin
                    if (r1_cnt == 0) r1_first = cyc;
                    r1_cnt++;
                    r1_last = cyc;
                    last1 = resp1_y;
                end
            end
            if (!resp0_valid) chk("hold_y0", resp0_y, last0);
            if (!resp1_valid) chk("hold_y1", resp1_y, last1);
            chk("inflight", 32'(inflight), 32'(cnt));
            if (int'(inflight) > peak) peak = int'(inflight);
            if (rst) begin
                sb.delete();
                cnt = 0;
                last0 = '0;
                last1 = '0;
            end else if (req0_ready || req1_ready) begin
                e.id    = req1_ready;
                e.y     = req1_ready ? fref(req1_x1, req1_x2) : fref(req0_x1, req0_x2);
                e.dz    = req1_ready ? (req1_x2[30:0] == 31'd0) : (req0_x2[30:0] == 31'd0);
                e.issue = cyc + 1;
                sb.push_back(e);
                cnt++;
            end
        end
    end

    typedef struct {
        logic        v0, v1;
        logic [31:0] a1, a2, b1, b2;
        logic        r0, r1;
    } vec_t;
    vec_t tbl [10];

    task automatic drive(input logic v0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic v1, input logic [31:0] b1, input logic [31:0] b2);
        req0_valid = v0; req0_x1 = a1; req0_x2 = a2;
        req1_valid = v1; req1_x1 = b1; req1_x2 = b2;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 32'h437F0000, 32'hC37F0000, 32'h40200000, 32'h40000000, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h437F0000, 32'hC37F0000, 32'h40200000, 32'h40000000, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'h437F0000, 32'hC37F0000, 32'h40200000, 32'h40000000, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'h437F0000, 32'hC37F0000, 32'h40200000, 32'h40000000, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'h40400000, 32'h40000000, 32'h0,        32'h0,        1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'h40400000, 32'h40000000, 32'h0,        32'h0,        1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'h0,        32'h0,        32'h40200000, 32'h40000000, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 32'h40400000, 32'h40000000, 32'h41200000, 32'h40A00000, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 32'h40400000, 32'h40000000, 32'h41200000, 32'h40A00000, 1'b0, 1'b1};

        // Reset with both requesters valid: ready must stay low.
        rst = 1'b1;
        drive(1'b1, 32'h40400000, 32'h40000000, 1'b1, 32'h40200000, 32'h40000000);
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_fdiv_x1", fdiv_x1, 32'd0);
        chk("rst_fdiv_x2", fdiv_x2, 32'd0);
        chk("rst_resp_v", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
`ifdef FDIV_SCHED_DZ_FLAG_EN
        chk("rst_dz", {30'd0, resp1_dz, resp0_dz}, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // Grant table, first vector lands in the cycle right after reset falls.
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v0, tbl[i].a1, tbl[i].a2, tbl[i].v1, tbl[i].b1, tbl[i].b2);
            @(negedge clk);
            chk($sformatf("grant0[%0d]", i), 32'(req0_ready), 32'(tbl[i].r0));
            chk($sformatf("grant1[%0d]", i), 32'(req1_ready), 32'(tbl[i].r1));
            @(posedge clk);
            #1;
        end
        idle(6);
        chk("peak_inflight", 32'(peak), 32'd3);
        chk("drain_inflight", 32'(inflight), 32'd0);

        // Five back-to-back req1 issues must return as five adjacent pulses.
        r1_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h3F000000 + 32'(i), 32'h40800000 + 32'(i * 3));
            @(posedge clk);
            #1;
        end
        idle(6);
        chk("stream_count", 32'(r1_cnt), 32'd5);
        chk("stream_span", 32'(r1_last - r1_first), 32'd4);
        chk("stream_inflight", 32'(inflight), 32'd0);

        // Reset one cycle after an issue: the operation must be discarded.
        drive(1'b1, 32'h40400000, 32'h40000000, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_hold_ready0", 32'(req0_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        r0_cnt = 0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("post_rst_x1", fdiv_x1, 32'd0);
        chk("post_rst_x2", fdiv_x2, 32'd0);
        chk("post_rst_y", resp0_y | resp1_y, 32'd0);
        chk("post_rst_v", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        chk("post_rst_inflight", 32'(inflight), 32'd0);
        @(posedge clk);
        #1;
        idle(6);
        chk("no_stale_resp0", 32'(r0_cnt), 32'd0);

`ifdef FDIV_SCHED_DZ_FLAG_EN
        // Divide-by-zero flag travels with the tag.
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h3F800000, 32'h80000000);
        @(posedge clk);
        #1 drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h3F800000, 32'h3F8CCCCD);
        @(posedge clk);
        #1;
        idle(6);
`endif

        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
